// File: rtl/coefficient_symbolizer.sv
// JPEG run/size symbolizer: zigzag coefficients in, R/S/amplitude symbols (ZRL, EOB) out.
// Optional DC_DPCM_EN: DC symbol encodes the difference from the previous block's DC.
module coefficient_symbolizer #(
  parameter int COEF_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  output logic [3:0]               sym_r,
  output logic [3:0]               sym_s,
  output logic [COEF_W-1:0]        sym_amp,
  output logic                     sym_dc,
  output logic                     sym_last,
  output logic                     sym_valid,
  input  logic                     sym_ready
);

  typedef enum logic [1:0] {ACCEPT, EMIT_ZRL, EMIT_COEF, EMIT_EOB} state_t;

  typedef struct packed {
    logic [3:0]        r;
    logic [3:0]        s;
    logic [COEF_W-1:0] amp;
    logic              dc;
    logic              last;
  } sym_t;

  typedef struct packed {
    logic [3:0]        s;
    logic [COEF_W-1:0] amp;
  } sa_t;

  localparam logic signed [COEF_W:0] SAT = {1'b0, {COEF_W{1'b1}}};
  localparam logic signed [COEF_W:0] ONE = {{COEF_W{1'b0}}, 1'b1};
  localparam sym_t ZRL_SYM = '{r: 4'd15, s: 4'd0, amp: '0, dc: 1'b0, last: 1'b0};
  localparam sym_t EOB_SYM = '{r: 4'd0,  s: 4'd0, amp: '0, dc: 1'b0, last: 1'b1};

  // Size category and one's-complement amplitude; sizes above COEF_W clamp to full scale.
  function automatic sa_t encode(input logic signed [COEF_W:0] v_in);
    logic signed [COEF_W:0] v;
    logic signed [COEF_W:0] vm1;
    logic [COEF_W:0]        mag;
    int                     s;
    sa_t                    res;
    v   = v_in;
    mag = v[COEF_W] ? -v : v;
    s   = 0;
    for (int i = 0; i <= COEF_W; i++) if (mag[i]) s = i + 1;
    if (s > COEF_W) begin
      v = v[COEF_W] ? -SAT : SAT;
      s = COEF_W;
    end
    vm1     = v - ONE;
    res.amp = '0;
    for (int i = 0; i < COEF_W; i++) if (i < s) res.amp[i] = (v > 0) ? v[i] : vm1[i];
    res.s = 4'(s);
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [3:0]        run_q, run_d;
  logic [1:0]        zrl_q, zrl_d;
  logic              valid_q, valid_d;
  sym_t              out_q, out_d;
  sym_t              lat_q, lat_d;
  logic signed [COEF_W:0] dc_val, ac_val;
  sa_t               dc_enc, ac_enc;
  sym_t              coef_sym;
  logic              coef_acc, sym_xfer;

`ifdef DC_DPCM_EN
  localparam logic signed [COEF_W:0] DIFF_MAX = {1'b0, {COEF_W{1'b1}}};
  localparam logic signed [COEF_W:0] DIFF_MIN = {1'b1, {COEF_W{1'b0}}};
  logic signed [COEF_W-1:0] prev_dc_q, prev_dc_d;
  logic signed [COEF_W+1:0] diff_wide;

  assign diff_wide = {{2{coef_in[COEF_W-1]}}, coef_in} - {{2{prev_dc_q[COEF_W-1]}}, prev_dc_q};

  always_comb begin
    dc_val = diff_wide[COEF_W:0];
    if (diff_wide[COEF_W+1] != diff_wide[COEF_W])
      dc_val = diff_wide[COEF_W+1] ? DIFF_MIN : DIFF_MAX;
  end
`else
  assign dc_val = {coef_in[COEF_W-1], coef_in};
`endif

  assign ac_val   = {coef_in[COEF_W-1], coef_in};
  assign dc_enc   = encode(dc_val);
  assign ac_enc   = encode(ac_val);
  assign coef_sym = '{r: run_q, s: ac_enc.s, amp: ac_enc.amp, dc: 1'b0, last: (idx_q == 6'd63)};

  assign coef_ready = (state_q == ACCEPT);
  assign coef_acc   = coef_valid && coef_ready;
  assign sym_xfer   = valid_q && sym_ready;

  assign sym_r     = out_q.r;
  assign sym_s     = out_q.s;
  assign sym_amp   = out_q.amp;
  assign sym_dc    = out_q.dc;
  assign sym_last  = out_q.last;
  assign sym_valid = valid_q;

  always_comb begin
    // NOTE: every next value is defaulted first so no branch can leave one unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    run_d   = run_q;
    zrl_d   = zrl_q;
    valid_d = valid_q;
    out_d   = out_q;
    lat_d   = lat_q;
`ifdef DC_DPCM_EN
    prev_dc_d = prev_dc_q;
`endif
    unique case (state_q)
      ACCEPT: if (coef_acc) begin
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'd0) begin
          out_d   = '{r: 4'd0, s: dc_enc.s, amp: dc_enc.amp, dc: 1'b1, last: 1'b0};
          valid_d = 1'b1;
          state_d = EMIT_COEF;
`ifdef DC_DPCM_EN
          prev_dc_d = coef_in;
`endif
        end else if (coef_in == '0) begin
          if (idx_q == 6'd63) begin
            // Trailing zeros collapse into EOB; any pending ZRLs are dropped.
            out_d   = EOB_SYM;
            valid_d = 1'b1;
            run_d   = '0;
            zrl_d   = '0;
            state_d = EMIT_EOB;
          end else if (run_q == 4'd15) begin
            run_d = '0;
            if (zrl_q != 2'd3) zrl_d = zrl_q + 2'd1;
          end else begin
            run_d = run_q + 4'd1;
          end
        end else begin
          run_d   = '0;
          valid_d = 1'b1;
          if (zrl_q != 2'd0) begin
            lat_d   = coef_sym;
            out_d   = ZRL_SYM;
            state_d = EMIT_ZRL;
          end else begin
            out_d   = coef_sym;
            state_d = EMIT_COEF;
          end
        end
      end
      EMIT_ZRL: if (sym_xfer) begin
        zrl_d = zrl_q - 2'd1;
        if (zrl_q == 2'd1) begin
          out_d   = lat_q;
          state_d = EMIT_COEF;
        end
      end
      EMIT_COEF: if (sym_xfer) begin
        valid_d = 1'b0;
        state_d = ACCEPT;
        if (out_q.last) begin
          idx_d = '0;
          run_d = '0;
          zrl_d = '0;
        end
      end
      EMIT_EOB: if (sym_xfer) begin
        valid_d = 1'b0;
        state_d = ACCEPT;
        idx_d   = '0;
        run_d   = '0;
        zrl_d   = '0;
      end
      default: state_d = ACCEPT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking ones stay in the comb block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCEPT;
      idx_q   <= '0;
      run_q   <= '0;
      zrl_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      lat_q   <= '0;
`ifdef DC_DPCM_EN
      prev_dc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      zrl_q   <= zrl_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      lat_q   <= lat_d;
`ifdef DC_DPCM_EN
      prev_dc_q <= prev_dc_d;
`endif
    end
  end

endmodule

// File: tb/tb_coefficient_symbolizer.sv
// Bench for coefficient_symbolizer: block-level symbol model, per-transfer scoreboard, directed blocks.
module tb_coefficient_symbolizer;
  localparam int CW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [CW-1:0] coef_in;
  logic                 coef_valid;
  logic                 coef_ready;
  logic [3:0]           sym_r;
  logic [3:0]           sym_s;
  logic [CW-1:0]        sym_amp;
  logic                 sym_dc;
  logic                 sym_last;
  logic                 sym_valid;
  logic                 sym_ready;

  coefficient_symbolizer #(.COEF_W(CW)) dut (
    .clk(clk), .rst(rst),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .sym_r(sym_r), .sym_s(sym_s), .sym_amp(sym_amp), .sym_dc(sym_dc),
    .sym_last(sym_last), .sym_valid(sym_valid), .sym_ready(sym_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int s;
    int amp;
    bit dc;
    bit last;
  } exp_t;
  typedef int blk_t [64];

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_prev = 0;
  bit   chk_en = 1'b1;
  bit   stall_req = 1'b0;
  int   stall_cnt;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void size_amp(input int v, output int s, output int amp);
    int m;
    m = (v < 0) ? -v : v;
    s = 0;
    while (m > 0) begin
      m = m >> 1;
      s++;
    end
    if (s > CW) begin
      s = CW;
      v = (v > 0) ? (1 << CW) - 1 : -((1 << CW) - 1);
    end
    amp = (v > 0) ? v : ((v - 1) & ((1 << s) - 1));
  endfunction

  // Expected symbol stream for a whole block, straight from the run/size rules.
  function automatic void model_block(input blk_t b);
    int s, amp, dv, run;
    dv = b[0];
`ifdef DC_DPCM_EN
    dv = b[0] - model_prev;
    model_prev = b[0];
`endif
    size_amp(dv, s, amp);
    exp_q.push_back('{r: 0, s: s, amp: amp, dc: 1'b1, last: 1'b0});
    run = 0;
    for (int i = 1; i < 64; i++) begin
      if (b[i] == 0) begin
        run++;
      end else begin
        while (run >= 16) begin
          exp_q.push_back('{r: 15, s: 0, amp: 0, dc: 1'b0, last: 1'b0});
          run -= 16;
        end
        size_amp(b[i], s, amp);
        exp_q.push_back('{r: run, s: s, amp: amp, dc: 1'b0, last: (i == 63)});
        run = 0;
      end
    end
    if (b[63] == 0) exp_q.push_back('{r: 0, s: 0, amp: 0, dc: 1'b0, last: 1'b1});
  endfunction

  initial begin
    sym_ready = 1'b1;
    stall_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req && stall_cnt < 5 && sym_valid && sym_r == 4'd15 && sym_s == 4'd0) begin
        sym_ready = 1'b0;
        stall_cnt++;
      end else begin
        sym_ready = 1'b1;
      end
    end
  end

  logic [CW+9:0] snap;
  logic [CW+9:0] cur;
  bit            held = 1'b0;
  exp_t          e;

  always @(negedge clk) begin
    cur = {sym_r, sym_s, sym_amp, sym_dc, sym_last};
    if (rst || !chk_en) begin
      held = 1'b0;
    end else if (sym_valid) begin
      check("coef_ready_while_pending", int'(coef_ready), 0);
      if (held) check("held_stable", int'(cur), int'(snap));
      if (sym_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_symbol", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sym_r", int'(sym_r), e.r);
          check("sym_s", int'(sym_s), e.s);
          check("sym_amp", int'(sym_amp), e.amp);
          check("sym_dc", int'(sym_dc), int'(e.dc));
          check("sym_last", int'(sym_last), int'(e.last));
        end
        held = 1'b0;
      end else begin
        held = 1'b1;
        snap = cur;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic send_coef(input int v, output bit ok);
    bit acc;
    coef_in    = CW'(v);
    coef_valid = 1'b1;
    ok         = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = coef_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_block(input blk_t b, input int lo, input int hi);
    bit ok;
    for (int i = lo; i <= hi; i++) begin
      send_coef(b[i], ok);
      if (!ok) begin
        check("coef_accept_timeout", 0, 1);
        break;
      end
    end
    coef_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(posedge clk);
    check("drain_remaining", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_blk(output blk_t b);
    for (int i = 0; i < 64; i++) b[i] = 0;
  endtask

  initial begin
    blk_t b;
    int   s, amp;
    rst        = 1'b1;
    coef_in    = '0;
    coef_valid = 1'b0;
    #3;
    check("rst_sym_valid", int'(sym_valid), 0);
    check("rst_sym_r", int'(sym_r), 0);
    check("rst_sym_s", int'(sym_s), 0);
    check("rst_sym_amp", int'(sym_amp), 0);
    check("rst_sym_dc_last", int'({sym_dc, sym_last}), 0);
    check("rst_coef_ready", int'(coef_ready), 1);
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;

    size_amp(-128, s, amp);
    check("model_s_m128", s, 8);
    check("model_amp_m128", amp, 127);
    size_amp(5, s, amp);
    check("model_amp_p5", amp, 5);
    size_amp(-3, s, amp);
    check("model_s_m3", s, 2);
    check("model_amp_m3", amp, 0);

    // DC=+5, AC1=-3, rest zero.
    clear_blk(b);
    b[0] = 5;
    b[1] = -3;
    model_block(b);
    check("t1_count", exp_q.size(), 3);
    check("t1_dc", exp_q[0].s * 1000 + exp_q[0].amp * 10 + int'(exp_q[0].dc), 3051);
    check("t1_ac", exp_q[1].r * 100 + exp_q[1].s * 10 + exp_q[1].amp, 20);
    check("t1_eob", exp_q[2].s * 10 + int'(exp_q[2].last), 1);
    send_block(b, 0, 63);
    drain();

    // 20 zeros then +1 at index 21: one ZRL, R4.
    clear_blk(b);
    b[21] = 1;
    model_block(b);
    check("t2_count", exp_q.size(), 4);
    check("t2_zrl", exp_q[1].r * 10 + exp_q[1].s, 150);
    check("t2_ac", exp_q[2].r * 100 + exp_q[2].s * 10 + exp_q[2].amp, 411);
    send_block(b, 0, 63);
    drain();

    // Nonzero coefficient 63 after 62 zeros: 3 ZRL, R14 S8, no EOB.
    clear_blk(b);
    b[0]  = 1;
    b[63] = -128;
    model_block(b);
    check("t3_count", exp_q.size(), 5);
    check("t3_last", exp_q[4].r * 100000 + exp_q[4].s * 10000 + exp_q[4].amp * 10 + int'(exp_q[4].last),
          1481271);
    send_block(b, 0, 63);
    drain();

    // Same as the ZRL block, with sym_ready held low for 5 cycles on the ZRL.
    stall_req = 1'b1;
    clear_blk(b);
    b[21] = 1;
    model_block(b);
    send_block(b, 0, 63);
    drain();
    stall_req = 1'b0;
    check("t4_stall_cycles", stall_cnt, 5);

    // Reset with a symbol pending after 10 coefficients.
    chk_en = 1'b0;
    clear_blk(b);
    b[0] = 3;
    b[9] = 7;
    send_block(b, 0, 9);
    check("pending_before_reset", int'(sym_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_sym_valid", int'(sym_valid), 0);
    check("mid_rst_sym_fields", int'({sym_r, sym_s, sym_amp, sym_dc, sym_last}), 0);
    check("mid_rst_coef_ready", int'(coef_ready), 1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    model_prev = 0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Fresh blocks DC=10 then DC=7, all AC zero.
    clear_blk(b);
    b[0] = 10;
    model_block(b);
    check("t5_dc10", exp_q[0].s * 100 + exp_q[0].amp, 410);
    send_block(b, 0, 0);
    check("after_rst_first_dc", int'({sym_valid, sym_dc}), 3);
    send_block(b, 1, 63);
    drain();

    b[0] = 7;
    model_block(b);
`ifdef DC_DPCM_EN
    check("t6_dc_diff", exp_q[0].s * 100 + exp_q[0].amp, 200);
`else
    check("t6_dc7", exp_q[0].s * 100 + exp_q[0].amp, 307);
`endif
    send_block(b, 0, 63);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
